// File: rtl/ppu_pkg.sv
// Shared types and sizes for the PPU OAM / sprite-evaluation slice.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SCAN  = 3'd2,
    COPY  = 3'd3,
    DONE  = 3'd4
  } eval_state_t;

  localparam int OAM_BYTES = 256;
  localparam int SEC_BYTES = 32;
  localparam int SPR_H8    = 8;
  localparam int SPR_H16   = 16;

endpackage

// File: rtl/oam_eval_if.sv
// Bus bundle between the OAM/evaluation block and its users (DMA, CPU, sprite fetch).
interface oam_eval_if #(
  parameter int LINE_W = 9
);
  logic              dma_en;
  logic [7:0]        dma_addr;
  logic [7:0]        bus_data;
  logic              cpu_addr_wr;
  logic              cpu_data_wr;
  logic [7:0]        cpu_rdata;
  logic              eval_start;
  logic [LINE_W-1:0] scanline;
  logic              size16;
  logic [4:0]        sec_rd_addr;
  logic [7:0]        sec_rd_data;
  logic              eval_busy;
  logic [3:0]        sprite_count;
  logic              sprite0_in;
  logic              overflow;

  modport master (
    output dma_en, dma_addr, bus_data, cpu_addr_wr, cpu_data_wr,
    output eval_start, scanline, size16, sec_rd_addr,
    input  cpu_rdata, sec_rd_data, eval_busy, sprite_count, sprite0_in, overflow
  );

  modport slave (
    input  dma_en, dma_addr, bus_data, cpu_addr_wr, cpu_data_wr,
    input  eval_start, scanline, size16, sec_rd_addr,
    output cpu_rdata, sec_rd_data, eval_busy, sprite_count, sprite0_in, overflow
  );
endinterface

// File: rtl/oam_ram.sv
// 256x8 primary OAM: one synchronous write port, two combinational read ports.
module oam_ram
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] cpu_raddr_i,
  output logic [7:0] cpu_rdata_o,
  input  logic [7:0] ev_raddr_i,
  output logic [7:0] ev_rdata_o
);

  logic [7:0] mem_q [OAM_BYTES];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign cpu_rdata_o = mem_q[cpu_raddr_i];
  assign ev_rdata_o  = mem_q[ev_raddr_i];

endmodule

// File: rtl/oam_eval.sv
// PPU primary OAM with DMA/CPU write access and per-scanline sprite evaluation
// into a secondary OAM read by the sprite-fetch stage.
module oam_eval
  import ppu_pkg::*;
#(
  parameter int SEC_SLOTS = 8,
  parameter int LINE_W    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  oam_eval_if.slave  bus
);

  localparam int SEC_N  = 4 * SEC_SLOTS;
  localparam int SEC_AW = $clog2(SEC_N);

  logic [7:0]        oamaddr_q;
  logic [7:0]        oamaddr_d;
  eval_state_t       state_q;
  logic [LINE_W-1:0] line_q;
  logic              size16_q;
  logic [5:0]        n_q;
  logic [1:0]        k_q;
  logic [SEC_AW-1:0] clr_q;
  logic [3:0]        count_q;
  logic              sprite0_q;
  logic              overflow_q;
  logic              busy_q;
  logic [7:0]        sec_q [SEC_N];

  logic              ram_we_s;
  logic [7:0]        ram_waddr_s;
  logic [7:0]        ev_raddr_s;
  logic [7:0]        ev_rdata_s;
  logic [7:0]        cpu_rdata_s;
  logic [1:0]        k_eff_s;
  logic [LINE_W-1:0] diff_s;
  logic [LINE_W-1:0] height_s;
  logic              hit_s;
  logic [SEC_AW-1:0] sec_wr_idx_s;

  oam_ram u_ram (
    .clk         (clk),
    .we_i        (ram_we_s),
    .waddr_i     (ram_waddr_s),
    .wdata_i     (bus.bus_data),
    .cpu_raddr_i (oamaddr_q),
    .cpu_rdata_o (cpu_rdata_s),
    .ev_raddr_i  (ev_raddr_s),
    .ev_rdata_o  (ev_rdata_s)
  );

  // DMA owns the write port when both strobe; the CPU write and its increment are lost.
  always_comb begin
    ram_we_s    = bus.dma_en | bus.cpu_data_wr;
    ram_waddr_s = bus.dma_en ? bus.dma_addr : oamaddr_q;
    oamaddr_d   = oamaddr_q;
    if (bus.cpu_addr_wr) begin
      oamaddr_d = bus.bus_data;
    end else if (bus.cpu_data_wr && !bus.dma_en) begin
      oamaddr_d = oamaddr_q + 8'd1;
    end else begin
      oamaddr_d = oamaddr_q;
    end
  end

  // Range test: unsigned wrap makes Y >= 0xF0 miss all visible lines naturally.
  always_comb begin
    k_eff_s      = (state_q == COPY) ? k_q : 2'd0;
    ev_raddr_s   = {n_q, k_eff_s};
    diff_s       = line_q - LINE_W'(ev_rdata_s);
    height_s     = size16_q ? LINE_W'(SPR_H16) : LINE_W'(SPR_H8);
    hit_s        = (diff_s < height_s);
    sec_wr_idx_s = SEC_AW'({count_q, 2'b00}) + SEC_AW'(k_eff_s);
  end

  // OAM address register ($2003 / $2004 auto-increment).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oamaddr_q <= 8'h00;
    end else begin
      oamaddr_q <= oamaddr_d;
    end
  end

  // Evaluation FSM with secondary OAM and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      line_q     <= '0;
      size16_q   <= 1'b0;
      n_q        <= 6'd0;
      k_q        <= 2'd0;
      clr_q      <= '0;
      count_q    <= 4'd0;
      sprite0_q  <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < SEC_N; i++) begin
        sec_q[i] <= 8'hFF;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.eval_start) begin
            line_q     <= bus.scanline;
            size16_q   <= bus.size16;
            count_q    <= 4'd0;
            sprite0_q  <= 1'b0;
            overflow_q <= 1'b0;
            n_q        <= 6'd0;
            k_q        <= 2'd0;
            clr_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= CLEAR;
          end
        end
        CLEAR: begin
          sec_q[clr_q] <= 8'hFF;
          clr_q        <= clr_q + SEC_AW'(1);
          if (clr_q == SEC_AW'(SEC_N - 1)) begin
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hit_s) begin
            if (count_q < 4'(SEC_SLOTS)) begin
              sec_q[sec_wr_idx_s] <= ev_rdata_s;
              if (n_q == 6'd0) begin
                sprite0_q <= 1'b1;
              end
              k_q     <= 2'd1;
              state_q <= COPY;
            end else begin
              overflow_q <= 1'b1;
              state_q    <= DONE;
            end
          end else if (n_q == 6'd63) begin
            state_q <= DONE;
          end else begin
            n_q <= n_q + 6'd1;
          end
        end
        COPY: begin
          sec_q[sec_wr_idx_s] <= ev_rdata_s;
          if (k_q == 2'd3) begin
            count_q <= count_q + 4'd1;
            k_q     <= 2'd0;
            if (n_q == 6'd63) begin
              state_q <= DONE;
            end else begin
              n_q     <= n_q + 6'd1;
              state_q <= SCAN;
            end
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdata    = cpu_rdata_s;
  assign bus.sec_rd_data  = sec_q[bus.sec_rd_addr];
  assign bus.eval_busy    = busy_q;
  assign bus.sprite_count = count_q;
  assign bus.sprite0_in   = sprite0_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_oam_eval.sv
// Scoreboard bench for oam_eval: evaluations are predicted from a behavioural
// sprite-selection model and checked by a monitor when eval_busy falls.
`timescale 1ns/1ps
module tb_oam_eval;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  oam_eval_if #(.LINE_W(9)) bus ();

  oam_eval #(.SEC_SLOTS(8), .LINE_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         chk_len;
    logic [31:0]  len;
    logic [3:0]   cnt;
    logic         s0;
    logic         ov;
    logic [255:0] sec;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  bit         mon_busy = 1'b0;
  logic [7:0] model_oam [256];
  logic [7:0] model_addr = 8'h00;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Sprite selection straight from the rules: first 8 sprites with y <= line < y+h.
  function automatic exp_t model_eval(int line, bit s16);
    exp_t e;
    int   h;
    int   found;
    bit   stop;
    h = s16 ? 16 : 8;
    found = 0;
    stop = 1'b0;
    e.sec = '1;
    e.s0 = 1'b0;
    e.ov = 1'b0;
    e.chk_len = 1'b1;
    e.len = 32'd0;
    for (int n = 0; n < 64; n++) begin
      if (!stop) begin
        int y;
        y = int'(model_oam[4*n]);
        if (line >= y && line < y + h) begin
          if (found == 8) begin
            e.ov = 1'b1;
            stop = 1'b1;
            e.len = 32'(32 + (n + 1) + 24 + 1);
          end else begin
            for (int k = 0; k < 4; k++) e.sec[(found*4+k)*8 +: 8] = model_oam[4*n+k];
            if (n == 0) e.s0 = 1'b1;
            found++;
          end
        end
      end
    end
    if (!e.ov) e.len = 32'(32 + 64 + 3*found + 1);
    e.cnt = 4'(found);
    return e;
  endfunction

  task automatic drive(bit dma, logic [7:0] da, bit ca, bit cd, logic [7:0] bd,
                       bit es, logic [8:0] ln, bit s16);
    @(negedge clk);
    bus.dma_en = dma;
    bus.dma_addr = da;
    bus.cpu_addr_wr = ca;
    bus.cpu_data_wr = cd;
    bus.bus_data = bd;
    bus.eval_start = es;
    bus.scanline = ln;
    bus.size16 = s16;
    if (dma) model_oam[da] = bd;
    else if (cd) begin
      model_oam[model_addr] = bd;
      model_addr = model_addr + 8'd1;
    end
    if (ca) model_addr = bd;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic dma_wr(logic [7:0] a, logic [7:0] d);
    drive(1'b1, a, 1'b0, 1'b0, d, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic set2003(logic [7:0] a);
    drive(1'b0, 8'h00, 1'b1, 1'b0, a, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic w2004(logic [7:0] d);
    drive(1'b0, 8'h00, 1'b0, 1'b1, d, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic check_rdata(string name);
    idle();
    chk(name, 32'(bus.cpu_rdata), 32'(model_oam[model_addr]));
  endtask

  task automatic all_y(logic [7:0] y);
    for (int n = 0; n < 64; n++) dma_wr(8'(4*n), y);
  endtask

  task automatic start_eval(logic [8:0] line, bit s16);
    exp_q.push_back(model_eval(int'(line), s16));
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, line, s16);
    idle();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_busy || bus.eval_busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: counts busy cycles, checks results and secondary OAM when busy drops.
  initial begin : monitor
    int   cyc;
    exp_t e;
    cyc = 0;
    bus.sec_rd_addr = 5'd0;
    forever begin
      @(negedge clk);
      if (bus.eval_busy === 1'b1) cyc++;
      else if (cyc != 0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_eval: got completion after %0d cycles expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.chk_len) chk("busy_len", 32'(cyc), e.len);
          chk("sprite_count", 32'(bus.sprite_count), 32'(e.cnt));
          chk("sprite0_in", 32'(bus.sprite0_in), 32'(e.s0));
          chk("overflow", 32'(bus.overflow), 32'(e.ov));
          for (int i = 0; i < 32; i++) begin
            bus.sec_rd_addr = 5'(i);
            #1;
            chk($sformatf("sec[%0d]", i), 32'(bus.sec_rd_data), 32'(e.sec[i*8 +: 8]));
          end
        end
        cyc = 0;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t ab;
    bus.dma_en = 1'b0;
    bus.dma_addr = 8'h00;
    bus.bus_data = 8'h00;
    bus.cpu_addr_wr = 1'b0;
    bus.cpu_data_wr = 1'b0;
    bus.eval_start = 1'b0;
    bus.scanline = 9'd0;
    bus.size16 = 1'b0;
    for (int i = 0; i < 256; i++) model_oam[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.eval_busy), 32'd0);
    chk("rst_count", 32'(bus.sprite_count), 32'd0);
    chk("rst_sprite0", 32'(bus.sprite0_in), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 256; k++) dma_wr(8'(k), 8'(k));
    check_rdata("rdata_pre2003");
    set2003(8'h10);
    check_rdata("rdata_2003");
    chk("rdata_2003_const", 32'(bus.cpu_rdata), 32'h10);

    set2003(8'hFE);
    w2004(8'hAA);
    w2004(8'hBB);
    w2004(8'hCC);
    check_rdata("rdata_after_wrap");
    chk("rdata_oam01_const", 32'(bus.cpu_rdata), 32'h01);
    set2003(8'hFE); check_rdata("oam_fe");
    set2003(8'hFF); check_rdata("oam_ff");
    set2003(8'h00); check_rdata("oam_00");
    chk("oam_00_const", 32'(bus.cpu_rdata), 32'hCC);

    set2003(8'h40);
    drive(1'b1, 8'h80, 1'b0, 1'b1, 8'h5A, 1'b0, 9'd0, 1'b0);
    check_rdata("collide_addr_kept");
    set2003(8'h80); check_rdata("collide_dma_lands");

    set2003(8'h30);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b0, 9'd0, 1'b0);
    check_rdata("addr_data_same_cycle");
    set2003(8'h30); check_rdata("addr_data_old_addr");

    all_y(8'hFF);
    dma_wr(8'd0, 8'h20);
    dma_wr(8'd20, 8'h1A);
    dma_wr(8'd40, 8'h30);
    idle();
    start_eval(9'h021, 1'b0);
    drain();

    exp_q.push_back(model_eval(32'h21, 1'b0));
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 9'h021, 1'b0);
    idle();
    repeat (48) @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 9'h030, 1'b1);
    idle();
    drain();

    ab.chk_len = 1'b0;
    ab.len = 32'd0;
    ab.cnt = 4'd0;
    ab.s0 = 1'b0;
    ab.ov = 1'b0;
    ab.sec = '1;
    exp_q.push_back(ab);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 9'h021, 1'b0);
    idle();
    repeat (33) @(negedge clk);
    rst_n = 1'b0;
    model_addr = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain();

    all_y(8'hFF);
    dma_wr(8'd12, 8'h50);
    idle();
    start_eval(9'h05F, 1'b1);
    drain();
    start_eval(9'h05F, 1'b0);
    drain();

    for (int n = 0; n < 9; n++) dma_wr(8'(4*n), 8'h40);
    idle();
    start_eval(9'h040, 1'b0);
    drain();

    repeat (10) begin
      int line;
      bit s16;
      line = int'($urandom_range(0, 261));
      s16 = 1'($urandom_range(0, 1));
      for (int n = 0; n < 64; n++) begin
        int r;
        int d;
        int y;
        r = int'($urandom_range(0, 7));
        d = int'($urandom_range(0, 18));
        if (r < 3 && line - d >= 0 && line - d <= 255) y = line - d;
        else y = int'($urandom_range(0, 255));
        dma_wr(8'(4*n), 8'(y));
        for (int k = 1; k < 4; k++) dma_wr(8'(4*n+k), 8'($urandom_range(0, 255)));
      end
      idle();
      start_eval(9'(line), s16);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_eval.md
Name: oam_eval

Overview:
- Downstream consumer of the OAM DMA engine: holds the PPU's 256-byte primary OAM and accepts DMA byte writes plus CPU $2003/$2004 accesses.
- Per scanline, runs sprite evaluation: selects the first 8 sprites whose Y range covers the target line and copies them into a 32-byte secondary OAM.
- The sprite-fetch stage of the PPU reads the secondary OAM.

Parameters:
SEC_SLOTS, 8, max sprites per line; secondary OAM = 4*SEC_SLOTS bytes (spec values below assume 8)
LINE_W, 9, width of scanline input

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
dma_en  in  1  DMA write strobe (OAM write cycle of the DMA engine)
dma_addr  in  8  OAM byte address for DMA write
bus_data  in  8  CPU data bus; DMA and CPU write data
cpu_addr_wr  in  1  one-cycle pulse: CPU write to $2003
cpu_data_wr  in  1  one-cycle pulse: CPU write to $2004
cpu_rdata  out  8  $2004 read value = oam[oamaddr]
eval_start  in  1  one-cycle pulse: begin evaluation
scanline  in  LINE_W  target line, sampled on eval_start
size16  in  1  1 = 8x16 sprites, sampled on eval_start
sec_rd_addr  in  5  secondary OAM read address
sec_rd_data  out  8  secondary OAM byte, combinational read
eval_busy  out  1  evaluation in progress
sprite_count  out  4  sprites found, 0..8
sprite0_in  out  1  sprite 0 was copied
overflow  out  1  a 9th in-range sprite was found

Behaviour:
- Reset: oamaddr=0, FSM=IDLE, eval_busy=0, sprite_count=0, sprite0_in=0, overflow=0, secondary OAM=all 0xFF. Primary OAM is not reset.
- Reset asserted mid-evaluation aborts immediately to these values.
- Primary writes, priority order:
  - dma_en: oam[dma_addr] <= bus_data; oamaddr unchanged.
  - Else cpu_data_wr: oam[oamaddr] <= bus_data; oamaddr++ (wraps 0xFF->0x00).
  - Simultaneous dma_en and cpu_data_wr: the CPU write and its increment are dropped.
  - cpu_addr_wr: oamaddr <= bus_data. If coincident with cpu_data_wr, the data write uses the old oamaddr, then oamaddr loads bus_data.
- Primary writes are accepted at all times, including during evaluation. Evaluation reads current contents.
- cpu_rdata is a combinational read of oam[oamaddr]; a write is visible the next cycle.
- FSM states: IDLE, CLEAR, SCAN, COPY, DONE.
  - IDLE: on eval_start, latch scanline/size16, clear count/sprite0_in/overflow, n=0, go CLEAR.
  - CLEAR: 32 cycles, writing 0xFF to secondary[0..31] one byte per cycle; then SCAN.
  - SCAN: 1 cycle per sprite n. y = oam[4n]; diff = scanline - {0,y} (LINE_W bits, unsigned). Hit iff diff < (size16 ? 16 : 8).
    - Hit and count<8: write secondary[4*count] = y; set sprite0_in if n==0; go COPY.
    - Hit and count==8: overflow=1; go DONE.
    - Miss: n==63 ? DONE : n++.
  - COPY: 3 cycles, k=1..3: secondary[4*count+k] = oam[4n+k]. On the k=3 cycle, count++; then n==63 ? DONE : n++, SCAN.
  - DONE: 1 cycle, then IDLE.
- Y values 0xF0..0xFF wrap so they never hit lines 0..239; no special casing.
- eval_busy: registered, high in every non-IDLE state.
  - Total busy length = 32 + 64 + 3k + 1 cycles for k copies, no overflow.
  - Overflow terminates early.
- eval_start while busy is ignored.
- Results (sprite_count, sprite0_in, overflow) hold until the next accepted eval_start.
- sec_rd_data during busy returns live, possibly partial contents.

Decomposition:
- Package ppu_pkg holds:
  - eval_state_t enum {IDLE, CLEAR, SCAN, COPY, DONE}
  - OAM_BYTES=256
  - SEC_BYTES=32
  - SPR_H8=8
  - SPR_H16=16
- Sub-module oam_ram: 256x8 array, one write port, two combinational read ports (CPU, eval).
- FSM, oamaddr and secondary OAM stay in oam_eval.

Test Plan:
- DMA fill oam[k]=k for k=0..255 via dma_en; then cpu_addr_wr with 0x10 -> cpu_rdata=0x10, oamaddr unchanged by DMA (cpu_rdata=0x00 before the $2003 write).
- $2003=0xFE, then $2004 writes 0xAA,0xBB,0xCC -> oam[FE]=AA, oam[FF]=BB, oam[00]=CC, cpu_rdata shows oam[01].
- Sprites 0 Y=0x20, 5 Y=0x1A, 10 Y=0x30, all others Y=0xFF; scanline 0x21, size16=0:
  - sprite_count=2, sprite0_in=1, overflow=0
  - secondary[0..7] = sprite0 then sprite5 bytes; [8..31]=0xFF
  - eval_busy high exactly 103 cycles
- Nine sprites Y=0x40, scanline 0x40 -> count=8, overflow=1, secondary holds sprites 0..7, busy ends early.
- Sprite 3 Y=0x50, scanline 0x5F: size16=1 -> count=1; size16=0 -> count=0.
- eval_start pulsed mid-SCAN is ignored (103-cycle length unchanged).
- rst_n low mid-COPY -> eval_busy=0, count=0, secondary all 0xFF.
- cpu_data_wr coincident with dma_en -> only the DMA write lands, oamaddr unchanged.
